// File: rtl/bm_dag1_capture.sv
// Capture FIFO for bm_dag1 DAG results: valid/ready in and out, occupancy, sticky drop flag.
// Define BM_DAG1_CAPTURE_PARITY_EN to add a per-entry parity bit driven on out_parity.
module bm_dag1_capture #(
  parameter int unsigned BITS  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [BITS-1:0]            in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [BITS-1:0]            out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
`ifdef BM_DAG1_CAPTURE_PARITY_EN
  output logic                       out_parity,
`endif
  output logic                       drop_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
  localparam logic [LW-1:0] LevelLast = LW'(DEPTH - 1);
  localparam logic [LW-1:0] LevelOne  = LW'(1);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            drop_err_q;
  logic            push, pop;

`ifdef BM_DAG1_CAPTURE_PARITY_EN
  logic par_q [DEPTH];
`endif

  assign in_ready  = (level_q != LevelFull);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Storage is reset, so the read-pointer entry already reads 0 while in reset.
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign drop_err  = drop_err_q;
`ifdef BM_DAG1_CAPTURE_PARITY_EN
  assign out_parity = par_q[rd_ptr_q];
`endif

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (push) state_d = StPartial;
      end
      StPartial: begin
        if (push && !pop && level_q == LevelLast) begin
          state_d = StFull;
        end else if (pop && !push && level_q == LevelOne) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) state_d = StPartial;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StEmpty;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (in_valid && !in_ready) begin
        drop_err_q <= 1'b1;
      end
    end
  end

`ifdef BM_DAG1_CAPTURE_PARITY_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= 1'b0;
      end
    end else if (push) begin
      par_q[wr_ptr_q] <= ^in_data;
    end
  end
`endif

endmodule

// File: tb/tb_bm_dag1_capture.sv
// Directed self-checking bench for bm_dag1_capture (BITS=2, DEPTH=4).
module tb_bm_dag1_capture;

  logic       clock;
  logic       resetn;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_ready;
  logic [2:0] level;
  logic       drop_err;
`ifdef BM_DAG1_CAPTURE_PARITY_EN
  logic       out_parity;
`endif

  int n_tests;
  int n_fail;

  bm_dag1_capture #(
    .BITS (2),
    .DEPTH(4)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .level    (level),
`ifdef BM_DAG1_CAPTURE_PARITY_EN
    .out_parity(out_parity),
`endif
    .drop_err (drop_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    #2 resetn = 1'b0;
    #1 resetn = 1'b1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 2'b00;
    out_ready = 1'b0;
    step();
    step();
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_drop_err", 32'(drop_err), 0);
    check("rst_out_data", 32'(out_data), 0);
    resetn = 1'b1;

    // Single-word transfer, pushed on the first edge after release.
    in_valid = 1'b1;
    in_data  = 2'b10;
    step();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 2);
    check("single_level", 32'(level), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_valid", 32'(out_valid), 0);
    check("single_pop_level", 32'(level), 0);

    // Fill, overflow, drain.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 2'(i);
      step();
    end
    check("fill_level", 32'(level), 4);
    check("fill_in_ready", 32'(in_ready), 0);
    check("fill_drop_clear", 32'(drop_err), 0);
    in_data = 2'b01;
    step();
    in_valid = 1'b0;
    check("ovf_drop_err", 32'(drop_err), 1);
    check("ovf_level", 32'(level), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_data%0d", i), 32'(out_data), 32'(i));
      step();
      check($sformatf("drain_level%0d", i), 32'(level), 32'(3 - i));
      check($sformatf("drain_in_ready%0d", i), 32'(in_ready), 1);
    end
    check("drain_valid", 32'(out_valid), 0);
    check("drop_sticky", 32'(drop_err), 1);
    out_ready = 1'b0;

    pulse_reset();
    check("clr_drop_err", 32'(drop_err), 0);

    // Continuous streaming across pointer wrap.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 2'(i % 4);
      step();
      check($sformatf("wrap_data%0d", i), 32'(out_data), 32'(i % 4));
      check($sformatf("wrap_level%0d", i), 32'(level), 1);
    end
    in_valid = 1'b0;
    step();
    check("wrap_end_level", 32'(level), 0);
    check("wrap_drop_err", 32'(drop_err), 0);
    out_ready = 1'b0;

    // Simultaneous push and pop at level 2.
    in_valid = 1'b1;
    in_data  = 2'b11;
    step();
    in_data  = 2'b01;
    step();
    check("sim_pre_level", 32'(level), 2);
    check("sim_pre_data", 32'(out_data), 3);
    in_data   = 2'b10;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("sim_level", 32'(level), 2);
    check("sim_data", 32'(out_data), 1);
    step();
    check("sim_drain_data", 32'(out_data), 2);
    step();
    check("sim_drain_level", 32'(level), 0);
    out_ready = 1'b0;

    // Reset mid-operation, applied between edges.
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 2'(i);
      step();
    end
    in_valid = 1'b0;
    check("mid_pre_level", 32'(level), 3);
    #2 resetn = 1'b0;
    #1;
    check("mid_async_valid", 32'(out_valid), 0);
    check("mid_async_level", 32'(level), 0);
    check("mid_async_data", 32'(out_data), 0);
    check("mid_async_in_ready", 32'(in_ready), 1);
    #1 resetn = 1'b1;
    step();
    check("mid_post_valid", 32'(out_valid), 0);
    check("mid_post_level", 32'(level), 0);
    in_valid = 1'b1;
    in_data  = 2'b10;
    step();
    in_valid = 1'b0;
    check("mid_first_push_data", 32'(out_data), 2);
    check("mid_first_push_level", 32'(level), 1);

`ifdef BM_DAG1_CAPTURE_PARITY_EN
    pulse_reset();
    check("par_rst", 32'(out_parity), 0);
    in_valid = 1'b1;
    in_data  = 2'b11;
    step();
    in_data  = 2'b01;
    step();
    in_valid = 1'b0;
    check("par_first", 32'(out_parity), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("par_second", 32'(out_parity), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bm_dag1_capture.md
BM_DAG1_CAPTURE -- requirements
Module: bm_dag1_capture

Interface
REQ-001 SHALL provide parameter BITS, default 2, giving the data width and matching the upstream bm_dag1 logic-DAG result width.
REQ-002 SHALL provide parameter DEPTH, default 4, giving the number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL provide port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: the upstream result on in_data is valid.
REQ-006 SHALL provide port in_data, input, BITS bits: the upstream DAG result word (the upstream `out`).
REQ-007 SHALL provide port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL provide port out_valid, output, 1 bit: out_data holds the oldest stored word.
REQ-009 SHALL provide port out_data, output, BITS bits: the oldest stored word.
REQ-010 SHALL provide port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-011 SHALL provide port level, output, log2(DEPTH)+1 bits: the current occupancy.
REQ-012 SHALL provide port drop_err, output, 1 bit: sticky flag set when a word was offered while the FIFO was full.

Function
REQ-013 SHALL push on a rising clock edge when in_valid=1 and in_ready=1, writing in_data at the write pointer.
REQ-014 SHALL pop on a rising clock edge when out_valid=1 and out_ready=1, advancing the read pointer.
REQ-015 SHALL drive in_ready = (level != DEPTH) and out_valid = (level != 0), both decoded combinationally from registered state only.
REQ-016 SHALL drive out_data from the storage entry at the read pointer; its value is don't-care when out_valid=0.
REQ-017 SHALL give a latency of 1 cycle: a word pushed at edge N appears on out_data with out_valid=1 after edge N; there is no combinational bypass from input to output.
REQ-018 SHALL implement a state machine with states EMPTY (level 0), PARTIAL (0 < level < DEPTH) and FULL (level = DEPTH).
REQ-019 SHALL make these state transitions: EMPTY->PARTIAL on push; PARTIAL->FULL on push without pop at level DEPTH-1; PARTIAL->EMPTY on pop without push at level 1; FULL->PARTIAL on pop; otherwise the state holds.
REQ-020 SHALL, on simultaneous push and pop in PARTIAL, leave level unchanged and advance both pointers.
REQ-021 SHALL ignore out_ready in EMPTY: there is no pop and no underflow; a push in EMPTY with out_ready=1 only pushes.
REQ-022 SHALL not push in FULL, since in_ready=0; a pop in FULL frees one entry, and in_ready rises only in the following cycle.
REQ-023 SHALL wrap both pointers modulo DEPTH without losing or duplicating data.
REQ-024 SHALL set drop_err to 1 on any edge where in_valid=1 and in_ready=0; it stays at 1 until reset, and the offered word is discarded.
REQ-025 SHALL keep storage contents unchanged when no push occurs.

Reset
REQ-026 SHALL, while resetn=0, asynchronously force the following: state EMPTY, pointers 0, level=0, out_valid=0, in_ready=1, drop_err=0, out_data=0.
REQ-027 SHALL, on reset asserted mid-operation, discard all stored words immediately without waiting for a clock edge.
REQ-028 SHALL allow the first push on the first rising edge after resetn deasserts.

Configuration
REQ-029 SHALL, when macro BM_DAG1_CAPTURE_PARITY_EN is defined, add output out_parity (1 bit) and store one parity bit per entry, computed at push as the XOR of in_data bits.
REQ-030 SHALL drive out_parity from the entry at the read pointer, with value 0 after reset.
REQ-031 SHALL, without the macro, have no out_parity port and no parity storage; all other behaviour is identical.

Verification
REQ-032 SHALL cover single-word transfer: reset, then push 2'b10 with out_ready=0 -> next cycle out_valid=1, out_data=2'b10, level=1; then out_ready=1 for one cycle -> out_valid=0, level=0.
REQ-033 SHALL cover fill and overflow: push 2'b00, 2'b01, 2'b10, 2'b11 with out_ready=0 -> level=4, in_ready=0; offer 2'b01 -> drop_err=1, level stays 4, and drain order is 00, 01, 10, 11.
REQ-034 SHALL cover wrap-around: 10 continuous pushes of 0,1,2,3,0,1,... with out_ready=1 every cycle -> the output sequence equals the input sequence, level stays at most 1, and drop_err=0.
REQ-035 SHALL cover simultaneous push and pop at level=2 -> level stays 2 and the oldest word is popped.
REQ-036 SHALL cover mid-operation reset: at level=3, pulse resetn low between clock edges -> out_valid=0 and level=0 immediately, with no stale word after release.
REQ-037 SHALL, with BM_DAG1_CAPTURE_PARITY_EN defined, cover parity: push 2'b11 then 2'b01 -> out_parity is 0 then 1.
